// File: rtl/fetch_pc_unit.sv
// MIPS instruction-fetch stage: PC register, next-PC mux, IF/ID register and
// saturating stall/flush counters. One BOOT cycle follows every reset.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic             fd_en,
    input  logic             fd_flush,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      reg_target,
    input  logic [31:0]      br_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      fd_ir,
    output logic [31:0]      fd_pc4,
    output logic             fd_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fd_ir_q, fd_ir_d;
    logic [31:0]      fd_pc4_q, fd_pc4_d;
    logic             fd_valid_q, fd_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;

    assign pc_plus4    = pc_q + 32'd4;
    // Jump target comes from the IF/ID copy of the jump, not the word being fetched.
    assign jump_target = {fd_pc4_q[31:28], fd_ir_q[25:0], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fd_ir_d     = fd_ir_q;
        fd_pc4_d    = fd_pc4_q;
        fd_valid_d  = fd_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                // A taken branch wins over a load-use stall.
                if (pc_sel == 2'd3) begin
                    pc_d = br_target;
                end else if (!pc_en) begin
                    pc_d = pc_q;
                end else if (pc_sel == 2'd2) begin
                    pc_d = jump_target;
                end else if (pc_sel == 2'd1) begin
                    pc_d = reg_target;
                end else begin
                    pc_d = pc_plus4;
                end

                if (fd_flush) begin
                    fd_ir_d    = NOP_INSTR;
                    fd_pc4_d   = 32'd0;
                    fd_valid_d = 1'b0;
                end else if (fd_en) begin
                    fd_ir_d    = imem_rdata;
                    fd_pc4_d   = pc_plus4;
                    fd_valid_d = 1'b1;
                end

                if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
                if (fd_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            fd_ir_q     <= NOP_INSTR;
            fd_pc4_q    <= 32'd0;
            fd_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fd_ir_q     <= fd_ir_d;
            fd_pc4_q    <= fd_pc4_d;
            fd_valid_q  <= fd_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign fd_ir     = fd_ir_q;
    assign fd_pc4    = fd_pc4_q;
    assign fd_valid  = fd_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit; expected values are queued as stimulus
// is applied and popped after the clock edge that should produce them.
module tb_fetch_pc_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic [1:0]       pc_sel;
    logic [31:0]      reg_target;
    logic [31:0]      br_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      pc;
    logic [31:0]      fd_ir;
    logic [31:0]      fd_pc4;
    logic             fd_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic        imem_ovr_en;
    logic [31:0] imem_ovr;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .fd_flush  (fd_flush),
        .pc_sel    (pc_sel),
        .reg_target(reg_target),
        .br_target (br_target),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .pc        (pc),
        .fd_ir     (fd_ir),
        .fd_pc4    (fd_pc4),
        .fd_valid  (fd_valid),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: returns addr|1 unless a test supplies a specific word.
    assign imem_rdata = imem_ovr_en ? imem_ovr : (imem_addr | 32'd1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        fd_flush   = 1'b0;
        pc_sel     = 2'd0;
        reg_target = 32'd0;
        br_target  = 32'd0;
        imem_ovr_en = 1'b0;
        imem_ovr   = 32'd0;
    endtask

    // Reset, pass the BOOT cycle, then jr to addr so RUN starts at a known PC.
    task automatic go_to(input logic [31:0] addr);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pc_sel     = 2'd1;
        reg_target = addr;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (pc !== 32'd0 || fd_ir !== 32'd0 || fd_pc4 !== 32'd0 || fd_valid !== 1'b0 ||
            stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%h ir=%h pc4=%h v=%b sc=%h fc=%h, want all zero",
                     pc, fd_ir, fd_pc4, fd_valid, stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (pc !== 32'd0 || fd_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_hold: pc=%h valid=%b, want pc=0 valid=0", pc, fd_valid);
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'(4 * (i + 1)));
            exp_q.push_back(32'(4 * i) | 32'd1);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (pc !== exp || imem_addr !== exp) begin
                errors++;
                $display("FAIL run_pc[%0d]: pc=%h addr=%h, want %h", i, pc, imem_addr, exp);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (fd_ir !== exp || fd_valid !== 1'b1) begin
                errors++;
                $display("FAIL run_ir[%0d]: ir=%h valid=%b, want %h valid=1",
                         i, fd_ir, fd_valid, exp);
            end
        end
    endtask

    task automatic test_stall();
        go_to(32'h20);
        tick();
        vectors++;
        if (pc !== 32'h24) begin
            errors++;
            $display("FAIL stall_setup: pc=%h, want 00000024", pc);
        end
        go_to(32'h1C);
        tick();
        // pc=0x20, fd_ir holds the word fetched at 0x1C
        pc_en = 1'b0;
        fd_en = 1'b0;
        tick();
        vectors++;
        if (pc !== 32'h20 || fd_ir !== 32'h1D || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_hold: pc=%h ir=%h sc=%h, want 00000020 0000001d 1",
                     pc, fd_ir, stall_cnt);
        end
        idle_inputs();
        tick();
        vectors++;
        if (pc !== 32'h24 || fd_ir !== 32'h21 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_release: pc=%h ir=%h sc=%h, want 00000024 00000021 1",
                     pc, fd_ir, stall_cnt);
        end
    endtask

    task automatic test_branch_in_stall();
        go_to(32'h40);
        pc_en     = 1'b0;
        pc_sel    = 2'd3;
        br_target = 32'h100;
        fd_flush  = 1'b1;
        tick();
        vectors++;
        if (pc !== 32'h100 || fd_ir !== 32'd0 || fd_pc4 !== 32'd0 || fd_valid !== 1'b0 ||
            flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL branch_stall: pc=%h ir=%h pc4=%h v=%b fc=%h sc=%h, want 100 0 0 0 1 1",
                     pc, fd_ir, fd_pc4, fd_valid, flush_cnt, stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_jump();
        go_to(32'h1000_0000);
        imem_ovr_en = 1'b1;
        imem_ovr    = 32'h0800_0010;
        tick();
        vectors++;
        if (fd_ir !== 32'h0800_0010 || fd_pc4 !== 32'h1000_0004) begin
            errors++;
            $display("FAIL jump_setup: ir=%h pc4=%h, want 08000010 10000004", fd_ir, fd_pc4);
        end
        idle_inputs();
        pc_sel   = 2'd2;
        fd_flush = 1'b1;
        tick();
        vectors++;
        if (pc !== 32'h1000_0040 || fd_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump: pc=%h valid=%b, want 10000040 0", pc, fd_valid);
        end
        idle_inputs();
        pc_sel     = 2'd1;
        reg_target = 32'h3C;
        tick();
        vectors++;
        if (pc !== 32'h3C) begin
            errors++;
            $display("FAIL jr: pc=%h, want 0000003c", pc);
        end
        idle_inputs();
        pc_sel = 2'd2;
        pc_en  = 1'b0;
        tick();
        vectors++;
        if (pc !== 32'h3C) begin
            errors++;
            $display("FAIL stalled_jump: pc=%h, want 0000003c", pc);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        tick();
        vectors++;
        if (pc !== 32'd0 || fd_pc4 !== 32'd0 || fd_ir !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h pc4=%h ir=%h, want 0 0 fffffffd", pc, fd_pc4, fd_ir);
        end
    endtask

    task automatic test_saturation();
        go_to(32'd0);
        pc_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back((i + 1 >= 15) ? 32'd15 : 32'(i + 1));
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (stall_cnt !== exp[CNT_W-1:0] || flush_cnt !== 4'd0) begin
                errors++;
                $display("FAIL stall_sat[%0d]: sc=%h fc=%h, want %h 0",
                         i, stall_cnt, flush_cnt, exp[CNT_W-1:0]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        go_to(32'h200);
        pc_en    = 1'b0;
        fd_flush = 1'b1;
        tick();
        vectors++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mid_setup: sc=%h fc=%h, want 1 1", stall_cnt, flush_cnt);
        end
        pc_sel    = 2'd3;
        br_target = 32'h500;
        rst       = 1'b1;
        tick();
        vectors++;
        if (pc !== 32'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || fd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: pc=%h sc=%h fc=%h v=%b, want 0 0 0 0",
                     pc, stall_cnt, flush_cnt, fd_valid);
        end
        // Controls stay active through BOOT and must be ignored there.
        rst = 1'b0;
        tick();
        vectors++;
        if (pc !== 32'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_boot: pc=%h sc=%h fc=%h, want 0 0 0", pc, stall_cnt, flush_cnt);
        end
        idle_inputs();
        tick();
        vectors++;
        if (pc !== 32'd4) begin
            errors++;
            $display("FAIL mid_run: pc=%h, want 00000004", pc);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_stall();
        test_branch_in_stall();
        test_jump();
        test_wrap();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
